// File: rtl/cpu_axi_pkg.sv
// Shared AXI encodings and the state encoding for the instruction-side
// sram-like to AXI read bridge.
package cpu_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_AR   = 3'd1;
    localparam logic [2:0] ST_R1   = 3'd2;
    localparam logic [2:0] ST_R2   = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_AR   = ST_AR,
        S_R1   = ST_R1,
        S_R2   = ST_R2,
        S_RESP = ST_RESP
    } inst_state_e;

endpackage

// File: rtl/inst_sram_like_to_axi.sv
// Instruction-side sram-like responder: turns one dual-word fetch request
// into a single AXI4 read burst (2 beats inside an 8-byte block, else 1)
// and returns the words with one-cycle data_ok pulses.
module inst_sram_like_to_axi
    import cpu_axi_pkg::*;
#(
    parameter int              ID_W   = 4,
    parameter logic [ID_W-1:0] AXI_ID = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_req,
    input  logic            inst_wr,
    input  logic [1:0]      inst_size,
    input  logic [31:0]     inst_addr,
    input  logic [31:0]     inst_wdata,
    output logic            inst_addr_ok,
    output logic            inst_data_ok1,
    output logic            inst_data_ok2,
    output logic [31:0]     inst_rdata1,
    output logic [31:0]     inst_rdata2,
    output logic            inst_err,
    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic            arvalid,
    input  logic            arready,
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready
);

    inst_state_e state_q, state_d;

    logic [31:0] addr_q;
    logic        two_q;
    logic        got2_q;
    logic        err_q;
    logic [31:0] rdata1_q;
    logic [31:0] rdata2_q;

    // Writes, size and rid carry no meaning for a single-outstanding read-only port.
    logic unused_inputs;
    assign unused_inputs = ^{inst_wr, inst_size, inst_wdata, rid};

    logic beat1;
    logic beat2;
    logic resp_bad;
    assign beat1    = (state_q == S_R1) && rvalid;
    assign beat2    = (state_q == S_R2) && rvalid;
    assign resp_bad = (rresp != AXI_RESP_OKAY);

    assign arid        = AXI_ID;
    assign araddr      = addr_q;
    assign inst_rdata1 = rdata1_q;
    assign inst_rdata2 = rdata2_q;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and output decode; AXI address fields only driven while arvalid is high.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d       = state_q;
        inst_addr_ok  = 1'b0;
        inst_data_ok1 = 1'b0;
        inst_data_ok2 = 1'b0;
        inst_err      = 1'b0;
        arvalid       = 1'b0;
        arlen         = 8'd0;
        arsize        = 3'b000;
        arburst       = 2'b00;
        rready        = 1'b0;
        case (state_q)
            S_IDLE: begin
                inst_addr_ok = inst_req;
                if (inst_req) state_d = S_AR;
            end
            S_AR: begin
                arvalid = 1'b1;
                arlen   = {7'd0, two_q};
                arsize  = AXI_SIZE_WORD;
                arburst = AXI_BURST_INCR;
                if (arready) state_d = S_R1;
            end
            S_R1: begin
                rready = 1'b1;
                if (rvalid) state_d = (rlast || !two_q) ? S_RESP : S_R2;
            end
            S_R2: begin
                rready = 1'b1;
                if (rvalid) state_d = S_RESP;
            end
            S_RESP: begin
                inst_data_ok1 = 1'b1;
                inst_data_ok2 = got2_q;
                inst_err      = err_q;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request latch, beat capture and error accumulation.
    always_ff @(posedge clk) begin
        // NOTE: the data registers are reset on purpose: a reset must drop any
        // captured instruction words, not just the control state.
        if (rst) begin
            addr_q   <= 32'd0;
            two_q    <= 1'b0;
            got2_q   <= 1'b0;
            err_q    <= 1'b0;
            rdata1_q <= 32'd0;
            rdata2_q <= 32'd0;
        end else begin
            if (inst_addr_ok) begin
                addr_q <= inst_addr;
                two_q  <= ~inst_addr[2];
            end
            if (beat1) begin
                rdata1_q <= rdata;
                err_q    <= err_q | resp_bad;
                got2_q   <= 1'b0;
            end
            if (beat2) begin
                rdata2_q <= rdata;
                err_q    <= err_q | resp_bad;
                got2_q   <= 1'b1;
            end
            if (state_q == S_RESP) err_q <= 1'b0;
        end
    end

endmodule
